alu_share_ctrl: RTL and testbench



---
 rtl/alu_share_if.sv | 17 +
 rtl/alu_share_ctrl.sv | 77 +++++++
 tb/tb_alu_share_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// alu_share_if: request/operand/result bundle between two requesters and the shared ALU controller
interface alu_share_if #(parameter int N = 4);
    logic         req0;
    logic [1:0]   op0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [1:0]   op1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         ack0;
    logic         ack1;
    logic [N-1:0] result;
    logic         busy;
    modport master (output req0, op0, a0, b0, req1, op1, a1, b1, input ack0, ack1, result, busy);
    modport slave  (input req0, op0, a0, b0, req1, op1, a1, b1, output ack0, ack1, result, busy);
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin time-sharing of one N-bit ALU between two requesters
module alu_share_ctrl #(parameter int N = 4) (
    input logic       clk,
    input logic       rst_n,
    alu_share_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic         gid_q, gid_d, last_q, last_d;
    logic         ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic         win;
    always_comb begin
        win      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        gid_d    = gid_q;
        last_d   = last_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (bus.req0 || bus.req1) begin
                state_d = EXEC;
                gid_d   = win;
                op_d    = win ? bus.op1 : bus.op0;
                a_d     = win ? bus.a1 : bus.a0;
                b_d     = win ? bus.b1 : bus.b0;
            end
            EXEC: begin
                state_d  = DONE;
                result_d = op_q == 2'd0 ? a_q + b_q :
                           op_q == 2'd1 ? a_q | b_q :
                           op_q == 2'd2 ? a_q - b_q : a_q ^ b_q;
            end
            DONE: begin
                state_d = IDLE;
                last_d  = gid_q;
            end
            default: state_d = IDLE;
        endcase
        // ack is registered on the EXEC->DONE edge so it is high exactly during DONE
        ack0_d = state_q == EXEC && !gid_q;
        ack1_d = state_q == EXEC && gid_q;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            gid_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            result_q <= result_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and randomized checks of the shared-ALU controller against an arithmetic model
module tb_alu_share_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rq [2];
    logic [1:0] opc [2];
    logic [3:0] aa [2];
    logic [3:0] bb [2];
    int         total = 0;
    int         bad = 0;

    alu_share_if #(.N(4)) bus();
    alu_share_ctrl #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    assign bus.req0 = rq[0];
    assign bus.op0  = opc[0];
    assign bus.a0   = aa[0];
    assign bus.b0   = bb[0];
    assign bus.req1 = rq[1];
    assign bus.op1  = opc[1];
    assign bus.a1   = aa[1];
    assign bus.b1   = bb[1];

    always #5 clk = ~clk;

    function automatic logic [3:0] model(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = (a + b) % 16;
            1: r = a | b;
            2: r = (a - b + 16) % 16;
            default: r = a ^ b;
        endcase
        return 4'(r);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rq[0] = 1'b1; opc[0] = 2'd0; aa[0] = 4'd9; bb[0] = 4'd10;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl ack0/ack1/busy=%b want 000", {bus.ack0, bus.ack1, bus.busy});
        end
        total++;
        if (bus.result !== 4'd0) begin bad++; $display("FAIL reset_result got=%0d want 0", bus.result); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ack0 !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL reset_edge1 ack0=%b busy=%b want 0/1", bus.ack0, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.ack0 !== 1'b1 || bus.result !== 4'd3) begin
            bad++; $display("FAIL reset_edge2 ack0=%b result=%0d want 1/3", bus.ack0, bus.result);
        end
        rq[0] = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_edge3 ack0=%b busy=%b want 0/0", bus.ack0, bus.busy);
        end
    endtask

    task automatic test_opcodes();
        logic [3:0] exp [4] = '{4'd3, 4'd11, 4'd15, 4'd3};
        logic saw1 = 1'b0;
        for (int op = 0; op < 4; op++) begin
            logic got = 1'b0;
            opc[0] = 2'(op); aa[0] = 4'd9; bb[0] = 4'd10; rq[0] = 1'b1;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (bus.ack1) saw1 = 1'b1;
                if (bus.ack0) got = 1'b1;
            end
            rq[0] = 1'b0;
            total++;
            if (!got) begin bad++; $display("FAIL op%0d_timeout ack0 never seen want pulse", op); end
            total++;
            if (bus.result !== exp[op]) begin bad++; $display("FAIL op%0d_result got=%0d want %0d", op, bus.result, exp[op]); end
            @(negedge clk);
            total++;
            if (bus.ack0 !== 1'b0) begin bad++; $display("FAIL op%0d_pulse ack0=%b one cycle later want 0", op, bus.ack0); end
        end
        total++;
        if (saw1) begin bad++; $display("FAIL op_ack1 ack1 seen=%b want 0", saw1); end
    endtask

    task automatic test_contention();
        int n = 0, gap = 0, exp_id = 0;
        logic seen = 1'b0;
        do_reset();
        opc[0] = 2'd0; aa[0] = 4'd1; bb[0] = 4'd1;
        opc[1] = 2'd3; aa[1] = 4'd6; bb[1] = 4'd3;
        rq[0] = 1'b1; rq[1] = 1'b1;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                total++;
                if ({bus.ack1, bus.ack0} !== (exp_id == 1 ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL cont_order grant%0d ack1/ack0=%b want id %0d", n, {bus.ack1, bus.ack0}, exp_id);
                end
                total++;
                if (bus.result !== (exp_id == 1 ? 4'd5 : 4'd2)) begin
                    bad++; $display("FAIL cont_result grant%0d got=%0d want %0d", n, bus.result, exp_id == 1 ? 5 : 2);
                end
                if (seen) begin
                    total++;
                    if (gap !== 1) begin bad++; $display("FAIL cont_gap grant%0d idle cycles=%0d want 1", n, gap); end
                end
                seen = 1'b1; gap = 0; exp_id ^= 1; n++;
            end else if (!bus.busy) gap++;
        end
        total++;
        if (n !== 6) begin bad++; $display("FAIL cont_count grants=%0d want 6", n); end
        rq[0] = 1'b0; rq[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_operand_stability();
        logic got = 1'b0;
        do_reset();
        rq[1] = 1'b1; opc[1] = 2'd2; aa[1] = 4'd5; bb[1] = 4'd2;
        @(posedge clk);
        #1 aa[1] = 4'd0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.ack1) got = 1'b1;
        end
        rq[1] = 1'b0;
        total++;
        if (!got || bus.result !== 4'd3) begin
            bad++; $display("FAIL stable_result ack1=%b result=%0d want 1/3", got, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic got = 1'b0;
        rq[0] = 1'b1; opc[0] = 2'd0; aa[0] = 4'd1; bb[0] = 4'd1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.ack0) got = 1'b1;
        end
        rq[0] = 1'b0;
        @(negedge clk);
        opc[1] = 2'd3; aa[1] = 4'd6; bb[1] = 4'd3;
        rq[0] = 1'b1; rq[1] = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000 || bus.result !== 4'd0) begin
            bad++; $display("FAIL midrst_outputs ack0/ack1/busy=%b result=%0d want 000/0", {bus.ack0, bus.ack1, bus.busy}, bus.result);
        end
        @(negedge clk);
        total++;
        if (bus.ack0 || bus.ack1) begin bad++; $display("FAIL midrst_noack ack0/ack1=%b%b want 00", bus.ack0, bus.ack1); end
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) got = 1'b1;
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        total++;
        if (!bus.ack0 || bus.ack1 || bus.result !== 4'd2) begin
            bad++; $display("FAIL midrst_prio ack0=%b ack1=%b result=%0d want 1/0/2", bus.ack0, bus.ack1, bus.result);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int pend [2] = '{0, 0};
        int dly [2];
        int opp [2] = '{0, 0};
        int done = 0, cyc = 0;
        logic [1:0] ack;
        dly[0] = $urandom_range(0, 3);
        dly[1] = $urandom_range(0, 3);
        while (done < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            ack = {bus.ack1, bus.ack0};
            if (ack == 2'b11) begin bad++; total++; $display("FAIL rand_both_ack cycle=%0d ack=11 want one-hot", cyc); end
            for (int k = 0; k < 2; k++) begin
                if (ack[k]) begin
                    total++;
                    if (pend[k] == 0 || bus.result !== model(opc[k], aa[k], bb[k])) begin
                        bad++; $display("FAIL rand_result req%0d pending=%0d got=%0d want %0d", k, pend[k], bus.result, model(opc[k], aa[k], bb[k]));
                    end
                    total++;
                    if (opp[k] > 1) begin bad++; $display("FAIL rand_starve req%0d opposing grants=%0d want <=1", k, opp[k]); end
                    if (pend[1-k] != 0) opp[1-k]++;
                    pend[k] = 0; opp[k] = 0; rq[k] = 1'b0;
                    dly[k] = $urandom_range(0, 3);
                    done++;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (pend[k] == 0 && !ack[k]) begin
                    if (dly[k] == 0) begin
                        opc[k] = 2'($urandom_range(0, 3));
                        aa[k] = 4'($urandom_range(0, 15));
                        bb[k] = 4'($urandom_range(0, 15));
                        rq[k] = 1'b1;
                        pend[k] = 1;
                    end else dly[k]--;
                end
            end
        end
        total++;
        if (done < 200) begin bad++; $display("FAIL rand_timeout completed=%0d want 200", done); end
        rq[0] = 1'b0; rq[1] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rq[k] = 1'b0; opc[k] = 2'd0; aa[k] = 4'd0; bb[k] = 4'd0;
        end
        rst_n = 1'b0;
        test_reset();
        test_opcodes();
        test_contention();
        test_operand_stability();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
